// File: rtl/rx_symbol_decoder.sv
// Receive-side symbol decoder: classifies joined bytes into 4-bit symbol codes,
// tracks packet/ordered-set framing, reports packet length and SKP ordered-set count.
module rx_symbol_decoder #(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned DLLP_LEN = 6,
  parameter logic [7:0]  SYM_COM  = 8'hBC,
  parameter logic [7:0]  SYM_PAD  = 8'hF7,
  parameter logic [7:0]  SYM_SKP  = 8'h1C,
  parameter logic [7:0]  SYM_STP  = 8'hFB,
  parameter logic [7:0]  SYM_SDP  = 8'h5C,
  parameter logic [7:0]  SYM_END  = 8'hFD,
  parameter logic [7:0]  SYM_EDB  = 8'hFE,
  parameter logic [7:0]  SYM_FTS  = 8'h3C,
  parameter logic [7:0]  SYM_IDL  = 8'h7C
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ENB,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  output logic [7:0]       OUT_DATA,
  output logic [3:0]       OUT_CTRL,
  output logic             OUT_VALID,
  output logic             OUT_SOP,
  output logic             OUT_EOP,
  output logic             OUT_NULL,
  output logic             OUT_ERR,
  output logic [LEN_W-1:0] OUT_PKT_LEN,
  output logic [7:0]       OUT_SKP_CNT,
  output logic [1:0]       OUT_STATE
);

  localparam logic [3:0] C_DATA = 4'd0;
  localparam logic [3:0] C_COM  = 4'd1;
  localparam logic [3:0] C_PAD  = 4'd2;
  localparam logic [3:0] C_SKP  = 4'd3;
  localparam logic [3:0] C_STP  = 4'd4;
  localparam logic [3:0] C_SDP  = 4'd5;
  localparam logic [3:0] C_END  = 4'd6;
  localparam logic [3:0] C_EDB  = 4'd7;
  localparam logic [3:0] C_FTS  = 4'd8;
  localparam logic [3:0] C_IDL  = 4'd9;

  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DLLP_LEN_L = LEN_W'(DLLP_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [1:0]       OS_LAST    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OS   = 2'd1,
    ST_TLP  = 2'd2,
    ST_DLLP = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [3:0]       os_type_q, os_type_nxt;
  logic [1:0]       os_cnt_q, os_cnt_nxt;
  logic [7:0]       skp_cnt_nxt;
  logic [LEN_W-1:0] pkt_len_nxt;
  logic             sop_nxt, eop_nxt, null_nxt, err_nxt;
  logic             idle_proc;
  logic             accept_c;
  logic [3:0]       code_c;

  assign accept_c = ENB & IN_VALID;

  // Inside a packet only END/EDB are control; elsewhere match the full symbol set
  always_comb begin
    code_c = C_DATA;
    if (state == ST_TLP || state == ST_DLLP) begin
      if (IN_DATA == SYM_END)      code_c = C_END;
      else if (IN_DATA == SYM_EDB) code_c = C_EDB;
    end else begin
      case (IN_DATA)
        SYM_COM: code_c = C_COM;
        SYM_PAD: code_c = C_PAD;
        SYM_SKP: code_c = C_SKP;
        SYM_STP: code_c = C_STP;
        SYM_SDP: code_c = C_SDP;
        SYM_END: code_c = C_END;
        SYM_EDB: code_c = C_EDB;
        SYM_FTS: code_c = C_FTS;
        SYM_IDL: code_c = C_IDL;
        default: code_c = C_DATA;
      endcase
    end
  end

  // Framing next-state; a broken ordered set falls through to IDLE handling of the same byte
  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    os_type_nxt = os_type_q;
    os_cnt_nxt  = os_cnt_q;
    skp_cnt_nxt = OUT_SKP_CNT;
    pkt_len_nxt = OUT_PKT_LEN;
    sop_nxt     = 1'b0;
    eop_nxt     = 1'b0;
    null_nxt    = 1'b0;
    err_nxt     = 1'b0;
    idle_proc   = 1'b0;

    case (state)
      ST_IDLE: idle_proc = 1'b1;

      ST_OS: begin
        if (os_cnt_q == 2'd0) begin
          if (code_c == C_SKP || code_c == C_FTS || code_c == C_IDL) begin
            os_type_nxt = code_c;
            os_cnt_nxt  = 2'd1;
          end else begin
            err_nxt   = 1'b1;
            idle_proc = 1'b1;
          end
        end else if (code_c == os_type_q) begin
          if (os_cnt_q == OS_LAST) begin
            state_nxt  = ST_IDLE;
            os_cnt_nxt = 2'd0;
            if (os_type_q == C_SKP && OUT_SKP_CNT != 8'hFF)
              skp_cnt_nxt = OUT_SKP_CNT + 8'd1;
          end else begin
            os_cnt_nxt = os_cnt_q + 2'd1;
          end
        end else begin
          err_nxt   = 1'b1;
          idle_proc = 1'b1;
        end
      end

      ST_TLP: begin
        if (code_c == C_END || code_c == C_EDB) begin
          eop_nxt     = 1'b1;
          null_nxt    = (code_c == C_EDB);
          err_nxt     = (len_q == '0);
          pkt_len_nxt = len_q;
          state_nxt   = ST_IDLE;
        end else if (len_q == MAX_LEN_L) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          len_nxt = len_q + LEN_ONE;
        end
      end

      ST_DLLP: begin
        if (code_c == C_END || code_c == C_EDB) begin
          eop_nxt     = 1'b1;
          null_nxt    = (code_c == C_EDB);
          err_nxt     = (code_c == C_EDB) || (len_q != DLLP_LEN_L);
          pkt_len_nxt = len_q;
          state_nxt   = ST_IDLE;
        end else if (len_q == DLLP_LEN_L) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          len_nxt = len_q + LEN_ONE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (idle_proc) begin
      state_nxt = ST_IDLE;
      case (code_c)
        C_COM: begin
          state_nxt   = ST_OS;
          os_type_nxt = C_DATA;
          os_cnt_nxt  = 2'd0;
        end
        C_STP: begin
          state_nxt = ST_TLP;
          sop_nxt   = 1'b1;
          len_nxt   = '0;
        end
        C_SDP: begin
          state_nxt = ST_DLLP;
          sop_nxt   = 1'b1;
          len_nxt   = '0;
        end
        C_PAD, C_IDL: ;
        default: err_nxt = 1'b1;
      endcase
    end
  end

  // State and output registers; pulses clear on any non-accepted cycle
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      os_type_q   <= C_DATA;
      os_cnt_q    <= 2'd0;
      OUT_DATA    <= 8'd0;
      OUT_CTRL    <= 4'd0;
      OUT_VALID   <= 1'b0;
      OUT_SOP     <= 1'b0;
      OUT_EOP     <= 1'b0;
      OUT_NULL    <= 1'b0;
      OUT_ERR     <= 1'b0;
      OUT_PKT_LEN <= '0;
      OUT_SKP_CNT <= 8'd0;
    end else begin
      OUT_VALID <= 1'b0;
      OUT_SOP   <= 1'b0;
      OUT_EOP   <= 1'b0;
      OUT_NULL  <= 1'b0;
      OUT_ERR   <= 1'b0;
      if (accept_c) begin
        state       <= state_nxt;
        len_q       <= len_nxt;
        os_type_q   <= os_type_nxt;
        os_cnt_q    <= os_cnt_nxt;
        OUT_DATA    <= IN_DATA;
        OUT_CTRL    <= code_c;
        OUT_VALID   <= 1'b1;
        OUT_SOP     <= sop_nxt;
        OUT_EOP     <= eop_nxt;
        OUT_NULL    <= null_nxt;
        OUT_ERR     <= err_nxt;
        OUT_PKT_LEN <= pkt_len_nxt;
        OUT_SKP_CNT <= skp_cnt_nxt;
      end
    end
  end

  assign OUT_STATE = state;

endmodule

// File: tb/tb_rx_symbol_decoder.sv
// Directed bench for rx_symbol_decoder: framing, ordered sets, length limits, gaps and reset.
module tb_rx_symbol_decoder;

  localparam int unsigned LEN_W = 6;

  logic             CLK = 1'b0;
  logic             reset;
  logic             ENB;
  logic [7:0]       IN_DATA;
  logic             IN_VALID;
  logic [7:0]       OUT_DATA;
  logic [3:0]       OUT_CTRL;
  logic             OUT_VALID, OUT_SOP, OUT_EOP, OUT_NULL, OUT_ERR;
  logic [LEN_W-1:0] OUT_PKT_LEN;
  logic [7:0]       OUT_SKP_CNT;
  logic [1:0]       OUT_STATE;

  int checks = 0;
  int errors = 0;

  rx_symbol_decoder dut (
    .CLK(CLK), .reset(reset), .ENB(ENB), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL), .OUT_VALID(OUT_VALID), .OUT_SOP(OUT_SOP),
    .OUT_EOP(OUT_EOP), .OUT_NULL(OUT_NULL), .OUT_ERR(OUT_ERR), .OUT_PKT_LEN(OUT_PKT_LEN),
    .OUT_SKP_CNT(OUT_SKP_CNT), .OUT_STATE(OUT_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    IN_DATA  = d;
    IN_VALID = v;
    ENB      = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    drive(d, 1'b1, 1'b1);
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] d, input logic [3:0] c,
                          input logic sop, input logic eop, input logic nul,
                          input logic err, input logic [1:0] st);
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'(1'b1));
    chk({tag, ".data"},  32'(OUT_DATA),  32'(d));
    chk({tag, ".ctrl"},  32'(OUT_CTRL),  32'(c));
    chk({tag, ".sop"},   32'(OUT_SOP),   32'(sop));
    chk({tag, ".eop"},   32'(OUT_EOP),   32'(eop));
    chk({tag, ".null"},  32'(OUT_NULL),  32'(nul));
    chk({tag, ".err"},   32'(OUT_ERR),   32'(err));
    chk({tag, ".state"}, 32'(OUT_STATE), 32'(st));
  endtask

  task automatic exp_gap(input string tag, input logic [7:0] d, input logic [1:0] st);
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'(1'b0));
    chk({tag, ".pulses"}, 32'({OUT_SOP, OUT_EOP, OUT_NULL, OUT_ERR}), 32'(4'b0000));
    chk({tag, ".data_hold"}, 32'(OUT_DATA), 32'(d));
    chk({tag, ".state_hold"}, 32'(OUT_STATE), 32'(st));
  endtask

  task automatic exp_all_zero(input string tag);
    chk({tag, ".data"}, 32'(OUT_DATA), 32'd0);
    chk({tag, ".ctrl"}, 32'(OUT_CTRL), 32'd0);
    chk({tag, ".pulses"}, 32'({OUT_VALID, OUT_SOP, OUT_EOP, OUT_NULL, OUT_ERR}), 32'd0);
    chk({tag, ".pkt_len"}, 32'(OUT_PKT_LEN), 32'd0);
    chk({tag, ".skp_cnt"}, 32'(OUT_SKP_CNT), 32'd0);
    chk({tag, ".state"}, 32'(OUT_STATE), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ENB = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    exp_all_zero("reset");
    reset = 1'b0;

    // Basic TLP: STP, 11..14, END
    send(8'hFB); exp_byte("tlp.stp", 8'hFB, 4'd4, 1, 0, 0, 0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h11 + i)); exp_byte("tlp.pay", 8'(8'h11 + i), 4'd0, 0, 0, 0, 0, 2'd2);
    end
    send(8'hFD); exp_byte("tlp.end", 8'hFD, 4'd6, 0, 1, 0, 0, 2'd0);
    chk("tlp.len", 32'(OUT_PKT_LEN), 32'd4);

    // PAD in IDLE is silent
    send(8'hF7); exp_byte("idle.pad", 8'hF7, 4'd2, 0, 0, 0, 0, 2'd0);

    // Two SKP ordered sets
    for (int k = 0; k < 2; k++) begin
      send(8'hBC); exp_byte("skp.com", 8'hBC, 4'd1, 0, 0, 0, 0, 2'd1);
      send(8'h1C); exp_byte("skp.s1", 8'h1C, 4'd3, 0, 0, 0, 0, 2'd1);
      send(8'h1C); exp_byte("skp.s2", 8'h1C, 4'd3, 0, 0, 0, 0, 2'd1);
      send(8'h1C); exp_byte("skp.s3", 8'h1C, 4'd3, 0, 0, 0, 0, 2'd0);
      chk("skp.cnt", 32'(OUT_SKP_CNT), 32'(k + 1));
    end

    // Broken ordered set: STP errors and opens a TLP in the same cycle
    send(8'hBC); send(8'h1C);
    send(8'hFB); exp_byte("os.brk", 8'hFB, 4'd4, 1, 0, 0, 1, 2'd2);
    chk("os.brk.skp", 32'(OUT_SKP_CNT), 32'd2);
    send(8'hBC); exp_byte("tlp.com_as_data", 8'hBC, 4'd0, 0, 0, 0, 0, 2'd2);
    send(8'hFD); exp_byte("tlp1.end", 8'hFD, 4'd6, 0, 1, 0, 0, 2'd0);
    chk("tlp1.len", 32'(OUT_PKT_LEN), 32'd1);

    // Empty TLP
    send(8'hFB); send(8'hFD); exp_byte("tlp0.end", 8'hFD, 4'd6, 0, 1, 0, 1, 2'd0);
    chk("tlp0.len", 32'(OUT_PKT_LEN), 32'd0);

    // Good DLLP (6 bytes) then short DLLP (5 bytes)
    send(8'h5C); exp_byte("dllp.sdp", 8'h5C, 4'd5, 1, 0, 0, 0, 2'd3);
    for (int i = 0; i < 6; i++) send(8'(8'h30 + i));
    chk("dllp.st", 32'(OUT_STATE), 32'd3);
    send(8'hFD); exp_byte("dllp.end", 8'hFD, 4'd6, 0, 1, 0, 0, 2'd0);
    chk("dllp.len", 32'(OUT_PKT_LEN), 32'd6);
    send(8'h5C);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
    send(8'hFD); exp_byte("dllp5.end", 8'hFD, 4'd6, 0, 1, 0, 1, 2'd0);
    chk("dllp5.len", 32'(OUT_PKT_LEN), 32'd5);

    // DLLP overflow on 7th byte, then DLLP ended by EDB
    send(8'h5C);
    for (int i = 0; i < 6; i++) send(8'(8'h30 + i));
    send(8'h36); exp_byte("dllp7.ovf", 8'h36, 4'd0, 0, 0, 0, 1, 2'd0);
    chk("dllp7.len_hold", 32'(OUT_PKT_LEN), 32'd5);
    send(8'h5C); send(8'h30); send(8'h31);
    send(8'hFE); exp_byte("dllp.edb", 8'hFE, 4'd7, 0, 1, 1, 1, 2'd0);
    chk("dllp.edb.len", 32'(OUT_PKT_LEN), 32'd2);

    // TLP at MAX_LEN, overflow on 33rd payload byte
    send(8'hFB);
    for (int i = 0; i < 32; i++) send(8'(8'h40 + i));
    chk("max.st", 32'(OUT_STATE), 32'd2);
    chk("max.eop", 32'(OUT_EOP), 32'd0);
    send(8'h99); exp_byte("max.ovf", 8'h99, 4'd0, 0, 0, 0, 1, 2'd0);
    chk("max.len_hold", 32'(OUT_PKT_LEN), 32'd2);
    send(8'hFB); send(8'h55);
    send(8'hFE); exp_byte("tlp.edb", 8'hFE, 4'd7, 0, 1, 1, 0, 2'd0);
    chk("tlp.edb.len", 32'(OUT_PKT_LEN), 32'd1);

    // Gapped TLP with valid bubbles and an enable-low stretch
    send(8'hFB); exp_byte("gap.stp", 8'hFB, 4'd4, 1, 0, 0, 0, 2'd2);
    drive(8'hFD, 1'b0, 1'b1); exp_gap("gap.b0", 8'hFB, 2'd2);
    send(8'h11); exp_byte("gap.p1", 8'h11, 4'd0, 0, 0, 0, 0, 2'd2);
    drive(8'h00, 1'b0, 1'b1); exp_gap("gap.b1", 8'h11, 2'd2);
    send(8'h12); exp_byte("gap.p2", 8'h12, 4'd0, 0, 0, 0, 0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      drive(8'hFD, 1'b1, 1'b0); exp_gap("gap.enb", 8'h12, 2'd2);
    end
    send(8'h13);
    drive(8'h00, 1'b0, 1'b1); exp_gap("gap.b2", 8'h13, 2'd2);
    send(8'h14);
    send(8'hFD); exp_byte("gap.end", 8'hFD, 4'd6, 0, 1, 0, 0, 2'd0);
    chk("gap.len", 32'(OUT_PKT_LEN), 32'd4);

    // Asynchronous reset mid-TLP, then END in IDLE is an error
    send(8'hFB); send(8'h21); send(8'h22); send(8'h23);
    chk("rst.pre_st", 32'(OUT_STATE), 32'd2);
    IN_VALID = 1'b0;
    #2 reset = 1'b1;
    #1 exp_all_zero("rst.mid");
    @(negedge CLK); reset = 1'b0;
    @(posedge CLK); #1;
    send(8'hFD); exp_byte("rst.end", 8'hFD, 4'd6, 0, 0, 0, 1, 2'd0);
    chk("rst.end.len", 32'(OUT_PKT_LEN), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
